// File: rtl/fmdll_lock_ctrl.sv
// Lock controller for the frequency-multiplying DLL: SAR acquisition in
// reference-injection mode, then PD-driven tracking in ring mode.
module fmdll_lock_ctrl #(
  parameter int CODE_W     = 10,
  parameter int N_W        = 4,
  parameter int SETTLE     = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    win_n,
  input  logic              pd_lead,
  input  logic              pd_lag,
  output logic [CODE_W-1:0] code,
  output logic [1:0]        sel,
  output logic              locked,
  output logic              busy,
  output logic              sat_err
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int STB_W = $clog2(LOCK_CNT + 1);
  localparam int MIS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
  localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE);
  localparam logic [STB_W-1:0]  STB_LIM  = STB_W'(LOCK_CNT);
  localparam logic [MIS_W-1:0]  MIS_LIM  = MIS_W'(UNLOCK_CNT);

  localparam logic [1:0] SEL_OFF  = 2'b10;
  localparam logic [1:0] SEL_INJ  = 2'b01;
  localparam logic [1:0] SEL_RING = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAR    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CODE_W-1:0]   code_r, code_s;
  logic [1:0]          sel_r, sel_s;
  logic                locked_r, locked_s;
  logic                busy_r, busy_s;
  logic                sat_err_r, sat_err_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [SET_W-1:0]    settle_r, settle_s;
  logic [N_W-1:0]      win_r, win_s;
  logic [STB_W-1:0]    stable_r, stable_s;
  logic [MIS_W-1:0]    miss_r, miss_s;

  logic [N_W-1:0]      win_load_s;
  logic                step_up_s, step_dn_s, corr_s;

  assign code    = code_r;
  assign sel     = sel_r;
  assign locked  = locked_r;
  assign busy    = busy_r;
  assign sat_err = sat_err_r;

  // A zero window length behaves as a one-cycle window.
  assign win_load_s = (win_n == {N_W{1'b0}}) ? N_W'(1) : win_n;
  assign step_up_s  = pd_lead & ~pd_lag;
  assign step_dn_s  = pd_lag & ~pd_lead;
  assign corr_s     = step_up_s | step_dn_s;

  // Next-state and next-output computation.
  always_comb begin
    state_s   = state_r;
    code_s    = code_r;
    sel_s     = sel_r;
    locked_s  = locked_r;
    busy_s    = busy_r;
    sat_err_s = sat_err_r;
    idx_s     = idx_r;
    settle_s  = settle_r;
    win_s     = win_r;
    stable_s  = stable_r;
    miss_s    = miss_r;

    case (state_r)
      ST_IDLE: begin
        sel_s  = SEL_OFF;
        busy_s = 1'b0;
        if (start) begin
          state_s  = ST_SAR;
          code_s   = CODE_MID;
          idx_s    = IDX_TOP;
          settle_s = SET_LOAD;
          sel_s    = SEL_INJ;
          busy_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SAR: begin
        if (settle_r <= SET_W'(1)) begin
          if (pd_lag) begin
            code_s[idx_r] = 1'b0;
          end else begin
            code_s[idx_r] = 1'b1;
          end
          if (idx_r != {IDX_W{1'b0}}) begin
            code_s[idx_r - IDX_W'(1)] = 1'b1;
            idx_s    = idx_r - IDX_W'(1);
            settle_s = SET_LOAD;
          end else begin
            state_s  = ST_TRACK;
            sel_s    = SEL_RING;
            win_s    = win_load_s;
            stable_s = {STB_W{1'b0}};
            miss_s   = {MIS_W{1'b0}};
          end
        end else begin
          settle_s = settle_r - SET_W'(1);
        end
      end

      ST_TRACK, ST_LOCKED: begin
        sel_s = SEL_RING;
        if (win_r <= N_W'(1)) begin
          win_s = win_load_s;
          // Saturated corrections leave the code alone but still count.
          if (step_up_s) begin
            if (code_r == CODE_MAX) begin
              sat_err_s = 1'b1;
            end else begin
              code_s = code_r + CODE_W'(1);
            end
          end else if (step_dn_s) begin
            if (code_r == {CODE_W{1'b0}}) begin
              sat_err_s = 1'b1;
            end else begin
              code_s = code_r - CODE_W'(1);
            end
          end else begin
            code_s = code_r;
          end

          if (state_r == ST_TRACK) begin
            if (corr_s) begin
              stable_s = {STB_W{1'b0}};
            end else if (stable_r + STB_W'(1) == STB_LIM) begin
              state_s  = ST_LOCKED;
              locked_s = 1'b1;
              stable_s = {STB_W{1'b0}};
              miss_s   = {MIS_W{1'b0}};
            end else begin
              stable_s = stable_r + STB_W'(1);
            end
          end else begin
            if (!corr_s) begin
              miss_s = {MIS_W{1'b0}};
            end else if (miss_r + MIS_W'(1) == MIS_LIM) begin
              state_s  = ST_TRACK;
              locked_s = 1'b0;
              stable_s = {STB_W{1'b0}};
              miss_s   = {MIS_W{1'b0}};
            end else begin
              miss_s = miss_r + MIS_W'(1);
            end
          end
        end else begin
          win_s = win_r - N_W'(1);
        end
      end

      default: begin
        state_s  = ST_IDLE;
        sel_s    = SEL_OFF;
        busy_s   = 1'b0;
        locked_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      code_r    <= {CODE_W{1'b0}};
      sel_r     <= SEL_OFF;
      locked_r  <= 1'b0;
      busy_r    <= 1'b0;
      sat_err_r <= 1'b0;
      idx_r     <= {IDX_W{1'b0}};
      settle_r  <= {SET_W{1'b0}};
      win_r     <= {N_W{1'b0}};
      stable_r  <= {STB_W{1'b0}};
      miss_r    <= {MIS_W{1'b0}};
    end else begin
      state_r   <= state_s;
      code_r    <= code_s;
      sel_r     <= sel_s;
      locked_r  <= locked_s;
      busy_r    <= busy_s;
      sat_err_r <= sat_err_s;
      idx_r     <= idx_s;
      settle_r  <= settle_s;
      win_r     <= win_s;
      stable_r  <= stable_s;
      miss_r    <= miss_s;
    end
  end

endmodule
